// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-family program sequencing blocks.
// Holds the default address width and the resolved sequencer operation type.
package sap_pkg;

    // Default width of the PC, return-address entries and bus slice.
    localparam int SAP_AW = 8;

    // One operation per edge, already resolved by priority and fault rules.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } seq_op_t;

endpackage

// File: rtl/lifo_ram.sv
// Return-address storage for pc_call_stack: DEPTH x AW words.
// Ports: clk; write port we/wa/wd (posedge); async read port ra -> rd.
module lifo_ram #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] wa,
    input  logic [AW-1:0] wd,
    input  logic [PW-1:0] ra,
    output logic [AW-1:0] rd
);

    logic [AW-1:0] r_mem [DEPTH];

    // Contents are never cleared; an empty stack hides them.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= wd;
        end
    end

    assign rd = r_mem[ra];

endmodule

// File: rtl/pc_call_stack.sv
// Program counter plus DEPTH-deep return-address stack for nested calls.
// Ports: clk, clr (sync, active-high); bus (inout AW); strobes lp, cp, ep,
//   call, ret; outputs pc, top, level, full, empty, err.
// Build option: PC_STACK_TRAP_EN selects trap mode (faults set sticky err
//   and freeze the block until clr); undefined selects wrap mode.
module pc_call_stack
    import sap_pkg::*;
#(
    parameter int AW    = SAP_AW,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    inout  wire  [AW-1:0]                bus,
    input  logic                         lp,
    input  logic                         cp,
    input  logic                         ep,
    input  logic                         call,
    input  logic                         ret,
    output logic [AW-1:0]                pc,
    output logic [AW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [AW-1:0] r_pc;
    logic [PW-1:0] r_wp;
    logic [LW-1:0] r_level;

    logic          w_full;
    logic          w_empty;
    logic          w_drive;
    logic          w_we;
    logic [PW-1:0] w_ra;
    logic [AW-1:0] w_rd;
    seq_op_t       w_op;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);

    // Top of stack sits just below the write pointer.
    assign w_ra = r_wp - PW'(1);

    // Never drive while the bus is being read by this block.
    assign w_drive = ep & ~lp & ~call;
    assign bus     = w_drive ? r_pc : 'z;

`ifdef PC_STACK_TRAP_EN
    logic r_err;
    logic w_fault;

    always_comb begin
        w_op    = OP_NONE;
        w_fault = 1'b0;
        priority case (1'b1)
            call: begin
                if (w_full) w_fault = 1'b1;
                else        w_op    = OP_CALL;
            end
            ret: begin
                if (w_empty) w_fault = 1'b1;
                else         w_op    = OP_RET;
            end
            lp:      w_op = OP_LOAD;
            cp:      w_op = OP_INC;
            default: w_op = OP_NONE;
        endcase
        // A raised fault freezes everything except clr.
        if (r_err) begin
            w_op    = OP_NONE;
            w_fault = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_err <= 1'b0;
        end else if (w_fault) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    always_comb begin
        w_op = OP_NONE;
        priority case (1'b1)
            // Full stack: push still happens and overwrites the oldest.
            call: w_op = OP_CALL;
            ret: begin
                if (!w_empty) w_op = OP_RET;
            end
            lp:      w_op = OP_LOAD;
            cp:      w_op = OP_INC;
            default: w_op = OP_NONE;
        endcase
    end

    assign err = 1'b0;
`endif

    assign w_we = (w_op == OP_CALL) & ~clr;

    lifo_ram #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .wa  (r_wp),
        .wd  (r_pc),
        .ra  (w_ra),
        .rd  (w_rd)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc    <= '0;
            r_wp    <= '0;
            r_level <= '0;
        end else begin
            unique case (w_op)
                OP_CALL: begin
                    r_pc <= bus;
                    r_wp <= r_wp + PW'(1);
                    // When full, wp already points at the oldest entry.
                    if (!w_full) r_level <= r_level + LW'(1);
                end
                OP_RET: begin
                    r_pc    <= w_rd;
                    r_wp    <= r_wp - PW'(1);
                    r_level <= r_level - LW'(1);
                end
                OP_LOAD: r_pc <= bus;
                OP_INC:  r_pc <= r_pc + AW'(1);
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign pc    = r_pc;
    assign top   = w_empty ? '0 : w_rd;
    assign level = r_level;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
